// File: rtl/sprite_pkg.sv
// Shared sprite geometry, sheet layout types and the sheet address helper used
// by the fetch stage and the sprite RAM.
package sprite_pkg;

  localparam int SPR_W  = 16;
  localparam int SPR_H  = 16;
  localparam int FRAMES = 3;
  localparam int ADDR_W = 19;
  localparam int IDX_W  = 5;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ANIM_IDLE   = 2'd0,
    ANIM_STEP_A = 2'd1,
    ANIM_MID    = 2'd2,
    ANIM_STEP_B = 2'd3
  } anim_state_t;

  // Sheet is laid out as rows of (direction, frame), each SPR_H lines of SPR_W pixels
  function automatic logic [ADDR_W-1:0] sheet_addr(
    input logic [ADDR_W-1:0] base,
    input logic [1:0]        dir,
    input logic [1:0]        frame,
    input logic [ADDR_W-1:0] dy,
    input logic [ADDR_W-1:0] dx
  );
    logic [ADDR_W-1:0] row;
    row = ADDR_W'(dir) * ADDR_W'(FRAMES) + ADDR_W'(frame);
    return base + (row * ADDR_W'(SPR_H) + dy) * ADDR_W'(SPR_W) + dx;
  endfunction

endpackage

// File: rtl/sprite_anim_fsm.sv
// Walk-animation sequencer advanced once per frame_tick; selects the sheet
// frame (0 stand, 1 step A, 2 step B).
module sprite_anim_fsm
  import sprite_pkg::*;
#(
  parameter int TICKS_PER_STEP = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       moving,
  output logic [1:0] frame
);

  localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);

  anim_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_next_b, w_next_b_nxt;
  logic [1:0]       r_frame;

  function automatic logic [1:0] frame_of(input anim_state_t st);
    case (st)
      ANIM_STEP_A: return 2'd1;
      ANIM_STEP_B: return 2'd2;
      default:     return 2'd0;
    endcase
  endfunction

  // Next-state logic; r_next_b remembers which step follows the MID pose
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_next_b_nxt = r_next_b;
    if (frame_tick) begin
      if (!moving) begin
        w_state_nxt = ANIM_IDLE;
        w_cnt_nxt   = '0;
      end else if (r_state == ANIM_IDLE) begin
        w_state_nxt = ANIM_STEP_A;
        w_cnt_nxt   = '0;
      end else if (r_cnt == CNT_LAST) begin
        w_cnt_nxt = '0;
        case (r_state)
          ANIM_STEP_A: begin
            w_state_nxt  = ANIM_MID;
            w_next_b_nxt = 1'b1;
          end
          ANIM_MID: w_state_nxt = r_next_b ? ANIM_STEP_B : ANIM_STEP_A;
          ANIM_STEP_B: begin
            w_state_nxt  = ANIM_MID;
            w_next_b_nxt = 1'b0;
          end
          default: w_state_nxt = ANIM_IDLE;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, counter, step flag and registered frame output
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= ANIM_IDLE;
      r_cnt    <= '0;
      r_next_b <= 1'b0;
      r_frame  <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_next_b <= w_next_b_nxt;
      r_frame  <= frame_of(w_state_nxt);
    end
  end

  assign frame = r_frame;

endmodule

// File: rtl/sprite_fetch.sv
// Sprite hit test and sheet address generation, realigned with the sprite RAM's
// one-cycle read latency; position/direction latched once per frame.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int                TICKS_PER_STEP = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 19'd0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [1:0]        dir,
  input  logic              moving,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pix_valid,
  output logic [ADDR_W-1:0] read_address,
  input  logic [IDX_W-1:0]  sprite_index,
  output logic              pixel_on,
  output logic [IDX_W-1:0]  palette_idx,
  output logic              out_valid
);

  logic [9:0]        r_sx, r_sy;
  dir_t              r_dir;
  logic [1:0]        w_frame;
  logic [10:0]       w_dx, w_dy;
  logic              w_hit, w_opaque;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_read_address;
  logic              r_hit1, r_pv1, r_hit2, r_pv2;
  logic              r_pixel_on, r_out_valid;
  logic [IDX_W-1:0]  r_palette_idx;

  sprite_anim_fsm #(.TICKS_PER_STEP(TICKS_PER_STEP)) u_anim (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_tick(frame_tick),
    .moving    (moving),
    .frame     (w_frame)
  );

  // Shadow position/direction, refreshed only at vertical blank
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sx  <= 10'd0;
      r_sy  <= 10'd0;
      r_dir <= DIR_DOWN;
    end else if (frame_tick) begin
      r_sx  <= sprite_x;
      r_sy  <= sprite_y;
      r_dir <= dir_t'(dir);
    end
  end

  // Bit 10 of the 11-bit difference flags pixels left of / above the sprite
  always_comb begin
    w_dx     = {1'b0, DrawX} - {1'b0, r_sx};
    w_dy     = {1'b0, DrawY} - {1'b0, r_sy};
    w_hit    = pix_valid & ~w_dx[10] & ~w_dy[10] &
               (w_dx < 11'(SPR_W)) & (w_dy < 11'(SPR_H));
    w_opaque = (sprite_index != {IDX_W{1'b0}});
    if (w_hit) begin
      w_addr = sheet_addr(BASE_ADDR, r_dir, w_frame, ADDR_W'(w_dy), ADDR_W'(w_dx));
    end else begin
      w_addr = BASE_ADDR;
    end
  end

  // Three-stage pipeline: address issue, RAM wait, colour resolve
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_read_address <= BASE_ADDR;
      r_hit1         <= 1'b0;
      r_pv1          <= 1'b0;
      r_hit2         <= 1'b0;
      r_pv2          <= 1'b0;
      r_pixel_on     <= 1'b0;
      r_palette_idx  <= {IDX_W{1'b0}};
      r_out_valid    <= 1'b0;
    end else begin
      r_read_address <= w_addr;
      r_hit1         <= w_hit;
      r_pv1          <= pix_valid;
      r_hit2         <= r_hit1;
      r_pv2          <= r_pv1;
      r_pixel_on     <= r_hit2 & w_opaque;
      r_palette_idx  <= (r_hit2 & w_opaque) ? sprite_index : {IDX_W{1'b0}};
      r_out_valid    <= r_pv2;
    end
  end

  assign read_address = r_read_address;
  assign pixel_on     = r_pixel_on;
  assign palette_idx  = r_palette_idx;
  assign out_valid    = r_out_valid;

endmodule

// File: doc/sprite_fetch.md
# sprite_fetch

Pixel-pipeline stage directly upstream of the character sprite RAM. For each VGA pixel it decides whether the pixel lies inside the player sprite and generates the sprite-sheet `read_address`. It realigns the RAM's registered 5-bit palette index with the pixel coordinates. It also runs the per-frame walk-animation state machine that selects the sprite-sheet frame.

## Interface
- `SPR_W`, 16: sprite width in pixels.
- `SPR_H`, 16: sprite height in pixels.
- `FRAMES`, 3: frames per direction in the sheet (0 = stand, 1 = step A, 2 = step B).
- `TICKS_PER_STEP`, 8: `frame_tick` pulses per animation step.
- `BASE_ADDR`, 0: sheet base address in sprite RAM.

Ports:
- `Clk`, in, 1: pixel clock; everything rises on it.
- `Reset`, in, 1: synchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse at the start of vertical blank.
- `sprite_x`, `sprite_y`, in, 10 each: sprite top-left screen position.
- `dir`, in, 2: facing direction (0 down, 1 up, 2 left, 3 right).
- `moving`, in, 1: character is walking.
- `DrawX`, `DrawY`, in, 10 each: current pixel.
- `pix_valid`, in, 1: `DrawX`/`DrawY` are in the visible area.
- `read_address`, out, 19: sprite RAM read address.
- `sprite_index`, in, 5: palette index returned by the sprite RAM one cycle after `read_address`.
- `pixel_on`, out, 1: sprite covers this pixel and it is opaque.
- `palette_idx`, out, 5: palette index for the pixel; 0 when `pixel_on` = 0.
- `out_valid`, out, 1: `pix_valid` delayed to align with `pixel_on`/`palette_idx`.

## Operation
- **Frame latch.** On `frame_tick`, latch `sprite_x`, `sprite_y`, `dir` and `moving` into shadow registers. Hit-test and address generation use only the shadow registers, so there is no mid-frame tearing.
- **Hit test (stage 1).**
  - `dx = {1'b0,DrawX} - {1'b0,sx}` and `dy = {1'b0,DrawY} - {1'b0,sy}`, both 11-bit.
  - `hit = pix_valid & ~dx[10] & ~dy[10] & dx < SPR_W & dy < SPR_H`.
  - Sprites partly off the right or bottom edge clip naturally; there is no wrap-around.
- **Address.**
  - `read_address = BASE_ADDR + ((dir*FRAMES + frame)*SPR_H + dy)*SPR_W + dx`, truncated to 19 bits.
  - When `hit` = 0, `read_address` holds `BASE_ADDR`.
- **Stage 2.** Delay `hit` and `pix_valid` by one cycle to match RAM latency.
- **Stage 3 (registered).**
  - `pixel_on = hit_d & (sprite_index != 0)`; index 0 is transparent.
  - `palette_idx = pixel_on ? sprite_index : 0`.
  - `out_valid = pix_valid_d`.
- **Animation FSM.** States IDLE, STEP_A, MID, STEP_B. The `frame` output per state is 0, 1, 0, 2 respectively.
  - Evaluated only on `frame_tick`, using the value of `moving` sampled on that same tick.
  - If `moving` = 0: go to IDLE and clear the tick counter.
  - If `moving` = 1 and state is IDLE: go to STEP_A and clear the counter.
  - Otherwise increment the counter. When it reaches `TICKS_PER_STEP-1`, clear it and advance STEP_A→MID→STEP_B→MID→STEP_A. MID tracks which step comes next with a 1-bit flag.
- **Direction change.** A new `dir` while moving does not reset the FSM; only the sheet row changes.

## Timing
- Latency is 3 cycles from `DrawX`/`DrawY`/`pix_valid` to `pixel_on`/`palette_idx`/`out_valid`.
- `read_address` is registered and valid 1 cycle after its `DrawX`.
- Throughput is one pixel per clock with no stalls.
- A new `frame_tick` takes effect on hit-test inputs from the cycle after the tick.
- **Reset values:**
  - All outputs 0, except `read_address` = `BASE_ADDR`.
  - FSM in IDLE; counter 0; step flag = A.
  - Shadow position and direction 0.
  - All pipeline valid/hit bits 0.
- **Reset mid-line.** Pixels already in flight are dropped; `out_valid` is 0 for the 3 cycles after `Reset` deasserts.
- **Simultaneous `Reset` and `frame_tick`.** `Reset` wins.

## Structure
- Package `sprite_pkg`:
  - `SPR_W`, `SPR_H`, `FRAMES`.
  - Direction enum `dir_t` (DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT).
  - `anim_state_t` enum.
  - `ADDR_W` = 19 and `IDX_W` = 5, shared with the sprite RAM.
- Sub-module `sprite_anim_fsm` (`Clk`, `Reset`, `frame_tick`, `moving` → `frame[1:0]`) holds the state, tick counter and step flag.
- `sprite_fetch` holds the shadow registers, hit test, address arithmetic and 3-stage pipeline.

## Test plan
- Hit window and address:
  - Setup: Reset; tick with `sprite_x`=100, `sprite_y`=50, `dir`=0, `moving`=0.
  - Sweep `DrawX` 98..117 on `DrawY`=50.
  - Required: `read_address` = 0..15 for `DrawX` 100..115, otherwise 0; `pixel_on` follows 3 cycles later.
- Transparency:
  - Stimulus: RAM model returns 0 for odd `dx`.
  - Required: `pixel_on`=0 and `palette_idx`=0 on those pixels; other pixels show the index.
- Address for direction and frame:
  - Stimulus: `dir`=3, `moving`=1, one tick → frame 1; pixel (`dx`=5, `dy`=2).
  - Required: `read_address` = ((3*3+1)*16+2)*16+5 = 2597.
- Animation sequence:
  - Stimulus: `moving`=1 for 33 ticks with `TICKS_PER_STEP`=8.
  - Required: frame sequence 1(×8), 0(×8), 2(×8), 0(×8), 1.
  - Then `moving`=0 on one tick → frame 0 immediately.
- Clipping:
  - Setup: `sprite_x`=632.
  - Required: `pixel_on` possible only for `DrawX` 632..639; never at `DrawX` 0..7.
  - Setup: `sprite_y`=0, `DrawY`=1023.
  - Required: no hit.
- Reset mid-line:
  - Stimulus: assert `Reset` during a hit run.
  - Required: next cycle all outputs 0 and `read_address`=`BASE_ADDR`; FSM frame 0 until the next tick with `moving`=1.
